// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 16 lines x 256 bits.
// A miss stalls the CPU while the victim is written back (if dirty) and the line is refilled.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    // state     | meaning
    // IDLE      | serve hits, detect misses
    // WRITEBACK | write dirty victim line to memory
    // ALLOCATE  | fetch requested line from memory
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state_q, state_d;

    logic [15:0]  valid_q;
    logic [15:0]  dirty_q;
    logic [22:0]  tag_q  [16];
    logic [255:0] data_q [16];

    logic [22:0] addr_tag;
    logic [3:0]  idx;
    logic [2:0]  word_sel;
    logic [7:0]  word_lsb;
    logic        hit;
    logic        fill;
    logic        unused_addr_bits;

    assign addr_tag         = cpu_addr_i[31:9];
    assign idx              = cpu_addr_i[8:5];
    assign word_sel         = cpu_addr_i[4:2];
    assign word_lsb         = {word_sel, 5'b0};
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit  = (state_q == IDLE) & cpu_req_i & valid_q[idx] & (tag_q[idx] == addr_tag);
    assign fill = (state_q == ALLOCATE) & mem_ack_i;

    assign cpu_data_o = hit ? data_q[idx][word_lsb +: 32] : 32'h0;

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = 256'h0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    cpu_stall_o = 1'b1;
                    state_d     = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, 5'b0};
                mem_data_o   = data_q[idx];
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {addr_tag, idx, 5'b0};
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (hit && cpu_we_i) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; a reset cycle simply blocks any update.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill) begin
                tag_q[idx]  <= addr_tag;
                data_q[idx] <= mem_data_i;
            end else if (hit && cpu_we_i) begin
                data_q[idx][word_lsb +: 32] <= cpu_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a cycle-level memory responder
// that acks on the Nth cycle of mem_enable_o.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [255:0] mem [logic [31:0]];
    int           wb_cnt;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [31:0]  al_addr;

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Default memory contents: word w of line a is (a ^ 0x5A5A0000) + w.
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = (a ^ 32'h5A5A_0000) + 32'(w);
        return r;
    endfunction

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int n_ack, output int stalls, output logic [31:0] rdata);
        int en_cnt = 0;
        int budget = 0;
        bit done   = 0;
        stalls  = 0;
        rdata   = '0;
        wb_cnt  = 0;
        wb_addr = '0;
        wb_data = '0;
        al_addr = '0;
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        while (!done && budget < 200) begin
            budget++;
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                rdata = cpu_data_o;
                done  = 1;
            end else begin
                stalls++;
                if (mem_enable_o) begin
                    en_cnt++;
                    if (en_cnt == n_ack) begin
                        en_cnt    = 0;
                        mem_ack_i = 1'b1;
                        if (mem_write_o) begin
                            wb_cnt++;
                            wb_addr = mem_addr_o;
                            wb_data = mem_data_o;
                            mem[mem_addr_o] = mem_data_o;
                        end else begin
                            al_addr    = mem_addr_o;
                            mem_data_i = mem_rd(mem_addr_o);
                        end
                    end
                end
            end
            @(posedge clk_i); #1;
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
        end
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        if (!done) chk("access_timeout", 256'(budget), 256'(0));
    endtask

    initial begin
        int           st;
        logic [31:0]  rd;
        logic [255:0] exp_line;

        mem[32'h100] = pat(32'h100);
        mem[32'h100][63:32] = 32'hDEAD_BEEF;

        // reset state
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_stall",   256'(cpu_stall_o),  256'(0));
        chk("rst_enable",  256'(mem_enable_o), 256'(0));
        chk("rst_write",   256'(mem_write_o),  256'(0));
        chk("rst_data",    256'(cpu_data_o),   256'(0));
        chk("rst_maddr",   256'(mem_addr_o),   256'(0));
        chk("rst_mdata",   mem_data_o,         256'(0));
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h104;
        #1;
        chk("rst_cold_stall", 256'(cpu_stall_o), 256'(1));
        chk("rst_cold_data",  256'(cpu_data_o),  256'(0));
        cpu_req_i = 1'b0;

        // cold load, N=10
        access(1'b0, 32'h104, 32'h0, 10, st, rd);
        chk("cold_stalls", 256'(st),      256'(11));
        chk("cold_aladdr", 256'(al_addr), 256'(32'h100));
        chk("cold_wbcnt",  256'(wb_cnt),  256'(0));
        chk("cold_data",   256'(rd),      256'(32'hDEAD_BEEF));

        // store hit then load hit
        access(1'b1, 32'h104, 32'h1234_5678, 10, st, rd);
        chk("sthit_stalls", 256'(st), 256'(0));
        access(1'b0, 32'h104, 32'h0, 10, st, rd);
        chk("ldhit_stalls", 256'(st), 256'(0));
        chk("ldhit_data",   256'(rd), 256'(32'h1234_5678));

        // conflicting load forces write-back of dirty line 8
        exp_line = pat(32'h100);
        exp_line[63:32] = 32'h1234_5678;
        access(1'b0, 32'h304, 32'h0, 10, st, rd);
        chk("dirty_stalls", 256'(st),      256'(21));
        chk("dirty_wbcnt",  256'(wb_cnt),  256'(1));
        chk("dirty_wbaddr", 256'(wb_addr), 256'(32'h100));
        chk("dirty_wbdata", wb_data,       exp_line);
        chk("dirty_aladdr", 256'(al_addr), 256'(32'h300));
        chk("dirty_data",   256'(rd),      256'(32'h5A5A_0301));

        // store miss on clean line, then conflict writes back merged line (N=3)
        access(1'b1, 32'h40, 32'hCAFE_F00D, 3, st, rd);
        chk("stmiss_stalls", 256'(st),     256'(4));
        chk("stmiss_wbcnt",  256'(wb_cnt), 256'(0));
        exp_line = pat(32'h40);
        exp_line[31:0] = 32'hCAFE_F00D;
        access(1'b0, 32'h240, 32'h0, 3, st, rd);
        chk("merge_stalls", 256'(st),      256'(7));
        chk("merge_wbaddr", 256'(wb_addr), 256'(32'h40));
        chk("merge_wbdata", wb_data,       exp_line);
        chk("merge_data",   256'(rd),      256'(32'h5A5A_0240));

        // reset during 5th ALLOCATE cycle, late ack afterwards
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h504;
        repeat (5) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_enable_before", 256'(mem_enable_o), 256'(1));
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        cpu_req_i  = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = {256{1'b1}};
        @(negedge clk_i);
        chk("midrst_enable_after", 256'(mem_enable_o), 256'(0));
        chk("midrst_stall_after",  256'(cpu_stall_o),  256'(0));
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        access(1'b0, 32'h304, 32'h0, 10, st, rd);
        chk("postrst_stalls", 256'(st),     256'(11));
        chk("postrst_wbcnt",  256'(wb_cnt), 256'(0));
        chk("postrst_data",   256'(rd),     256'(32'h5A5A_0301));

        // spurious ack while idle
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b1;
        mem_data_i = {256{1'b1}};
        @(negedge clk_i);
        chk("spur_enable", 256'(mem_enable_o), 256'(0));
        @(posedge clk_i); #1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        access(1'b0, 32'h304, 32'h0, 10, st, rd);
        chk("spur_stalls", 256'(st), 256'(0));
        chk("spur_data",   256'(rd), 256'(32'h5A5A_0301));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i is the clock, rst_i is the synchronous active-high reset.
REQ-002 clk_i  in  1  clock; all state changes on rising edge.
REQ-003 rst_i  in  1  reset, sampled on clk_i rising edge.
REQ-004 cpu_req_i  in  1  MEM-stage access request (MemRead or MemWrite from EX/MEM).
REQ-005 cpu_we_i  in  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  in  32  byte address (ALU result).
REQ-007 cpu_data_i  in  32  store data (rs2 data).
REQ-008 cpu_data_o  out  32  load data.
REQ-009 cpu_stall_o  out  1  freezes PC/IF/ID/ID-EX/EX-MEM (drives mem_stall).
REQ-010 mem_enable_o  out  1  memory request valid.
REQ-011 mem_write_o  out  1  1 = line write-back, 0 = line fetch.
REQ-012 mem_addr_o  out  32  line-aligned memory address, [4:0] = 0.
REQ-013 mem_data_o  out  256  line being written back.
REQ-014 mem_data_i  in  256  fetched line, valid when mem_ack_i = 1.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse for current request.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate: 16 lines x 256 bits, each line with a valid bit, a dirty bit and a 23-bit tag.
REQ-017 Address split SHALL be: tag = [31:9], index = [8:5], word = [4:2]; [1:0] ignored.
REQ-018 hit SHALL be cpu_req_i & valid[index] & (tag[index] == addr tag), evaluated combinationally in IDLE only.
REQ-019 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE.
REQ-020 IDLE, no request: cpu_stall_o = 0, mem_enable_o = 0, stay IDLE.
REQ-021 IDLE, load hit: cpu_data_o = selected word (same cycle, combinational), cpu_stall_o = 0.
REQ-022 IDLE, store hit: cpu_stall_o = 0; at the clock edge the selected word SHALL be replaced with cpu_data_i and dirty[index] set.
REQ-023 IDLE, miss: cpu_stall_o = 1 in the same cycle; next state WRITEBACK if valid & dirty, else ALLOCATE.
REQ-024 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, index, 5'b0}, mem_data_o = line; on mem_ack_i, next state ALLOCATE.
REQ-025 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}; on mem_ack_i, the line SHALL be loaded from mem_data_i, with the tag updated, valid = 1, dirty = 0, and next state IDLE.
REQ-026 The request SHALL then be serviced as a hit in IDLE; a store miss merges its word at that point, so dirty = 1.
REQ-027 cpu_stall_o SHALL be 1 in every WRITEBACK and ALLOCATE cycle.
REQ-028 mem_enable_o SHALL be held high until mem_ack_i; the cycle after a WRITEBACK ack begins a new fetch request (back-to-back allowed).
REQ-029 mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-030 CPU inputs SHALL be treated as stable while cpu_stall_o = 1; a cpu_req_i drop mid-miss SHALL NOT abort the transaction (the fill completes, no store merge occurs).
REQ-031 Latency for a memory acking on the Nth cycle of enable: clean miss stalls N+1 cycles; dirty miss stalls 2N+1 cycles; hit stalls 0 cycles.
REQ-032 mem_data_o and mem_addr_o SHALL be 0 when mem_enable_o = 0.

Reset
REQ-033 While rst_i = 1 at a clock edge: state -> IDLE, all valid and dirty bits cleared, tags and data unchanged (don't care).
REQ-034 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transaction with no line update; the next cycle has mem_enable_o = 0.
REQ-035 Outputs after reset: cpu_stall_o = cpu_req_i (cold miss), mem_enable_o = 0, mem_write_o = 0, cpu_data_o = 0 when not hit.

Verification
REQ-036 Cold load 0x0000_0104, memory acks on cycle 10 with word1 = 0xDEADBEEF -> 11 stall cycles, ALLOCATE addr 0x0000_0100, then cpu_data_o = 0xDEADBEEF.
REQ-037 Store 0x12345678 to 0x104 (hit) then load 0x104 -> 0 stall cycles, data 0x12345678, dirty[8] = 1.
REQ-038 Load 0x0000_0304 (same index 8, new tag) -> WRITEBACK to 0x100 with stored word present, then ALLOCATE 0x300; 21 stall cycles at N = 10.
REQ-039 Store miss to clean line 0x0000_0040 -> fill, merge, dirty = 1; later conflicting access 0x0000_0240 causes a write-back of the merged line.
REQ-040 rst_i pulsed in the 5th ALLOCATE cycle, late mem_ack_i arrives -> ack ignored, valid cleared, next access misses again.
REQ-041 Spurious mem_ack_i in IDLE with cpu_req_i = 0 -> no state, tag or data change.
